// File: rtl/rr_arb_quadmux_64bit.sv
// rtl/rr_arb_quadmux_64bit.sv - four-channel round-robin arbiter around a 64-bit 4:1 mux
// Picks one requester per cycle, registers its word and hands it downstream with valid/ready.

module quadmux_64bit (
   input  logic [63:0] InA,
   input  logic [63:0] InB,
   input  logic [63:0] InC,
   input  logic [63:0] InD,
   input  logic [1:0]  S,
   output logic [63:0] Out
);
   always_comb begin
      unique case (S)
         2'd0:    Out = InA;
         2'd1:    Out = InB;
         2'd2:    Out = InC;
         default: Out = InD;
      endcase
   end
endmodule

module rr_arb_quadmux_64bit #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] InA,
   input  logic [WIDTH-1:0] InB,
   input  logic [WIDTH-1:0] InC,
   input  logic [WIDTH-1:0] InD,
   input  logic [3:0]       ValidIn,
   output logic [3:0]       ReadyIn,
   output logic [WIDTH-1:0] Out,
   output logic             ValidOut,
   input  logic             ReadyOut,
   output logic [1:0]       Grant
);
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   logic [1:0]       grant_q, grant_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       sel;
   logic [1:0]       idx;
   logic             found;
   logic             load_en;
   logic [WIDTH-1:0] mux_out;

   quadmux_64bit u_mux (
      .InA (InA),
      .InB (InB),
      .InC (InC),
      .InD (InD),
      .S   (sel),
      .Out (mux_out)
   );

   // First requester at or after the pointer, wrapping modulo 4.
   always_comb begin
      sel   = ptr_q;
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + k[1:0];
         if (!found && ValidIn[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   assign load_en = (~valid_q | ReadyOut) & (|ValidIn);

   always_comb begin
      ReadyIn = 4'b0000;
      if (rst_n && load_en)
         ReadyIn[sel] = 1'b1;
   end

   always_comb begin
      out_d   = out_q;
      valid_d = valid_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      if (load_en) begin
         out_d   = mux_out;
         valid_d = 1'b1;
         grant_d = sel;
         ptr_d   = sel + 2'd1;
      end else if (valid_q && ReadyOut) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         valid_q <= 1'b0;
         grant_q <= 2'd0;
         ptr_q   <= 2'd0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign Out      = out_q;
   assign ValidOut = valid_q;
   assign Grant    = grant_q;
endmodule

// File: tb/tb_rr_arb_quadmux_64bit.sv
// tb/tb_rr_arb_quadmux_64bit.sv - directed self-checking bench for rr_arb_quadmux_64bit

module tb_rr_arb_quadmux_64bit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] InA, InB, InC, InD;
   logic [3:0]  ValidIn;
   logic [3:0]  ReadyIn;
   logic [63:0] Out;
   logic        ValidOut;
   logic        ReadyOut;
   logic [1:0]  Grant;

   int checks = 0;
   int errors = 0;

   rr_arb_quadmux_64bit #(.WIDTH(64)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .InA      (InA),
      .InB      (InB),
      .InC      (InC),
      .InD      (InD),
      .ValidIn  (ValidIn),
      .ReadyIn  (ReadyIn),
      .Out      (Out),
      .ValidOut (ValidOut),
      .ReadyOut (ReadyOut),
      .Grant    (Grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [63:0] o, input logic [1:0] g, input logic v);
      chk({tag, ".out"}, Out, o);
      chk({tag, ".grant"}, {62'd0, Grant}, {62'd0, g});
      chk({tag, ".valid"}, {63'd0, ValidOut}, {63'd0, v});
   endtask

   initial begin
      logic [63:0] exp_rr [5];
      logic [1:0]  exp_g  [5];
      exp_rr = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd1};
      exp_g  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      rst_n = 1'b0; ValidIn = 4'b0000; ReadyOut = 1'b0;
      InA = 64'd0; InB = 64'd0; InC = 64'd0; InD = 64'd0;
      #12;
      chk_out("rst", 64'd0, 2'd0, 1'b0);
      chk("rst.ready_in", {60'd0, ReadyIn}, 64'd0);
      rst_n = 1'b1;
      step(); step();
      chk_out("post_rst", 64'd0, 2'd0, 1'b0);
      chk("post_rst.ready_in", {60'd0, ReadyIn}, 64'd0);

      // Round robin from pointer 0 with all channels requesting.
      InA = 64'd1; InB = 64'd2; InC = 64'd3; InD = 64'd4;
      ValidIn = 4'b1111; ReadyOut = 1'b1;
      #1;
      chk("rr.ready_in0", {60'd0, ReadyIn}, 64'b0001);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_out($sformatf("rr%0d", i), exp_rr[i], exp_g[i], 1'b1);
      end

      // Pointer now 1: 1001 must grant D first, then A.
      InA = 64'hAAAA_0000_0000_0000; InD = 64'hDDDD_0000_0000_0003;
      ValidIn = 4'b1001;
      #1;
      chk("skip.ready_in", {60'd0, ReadyIn}, 64'b1000);
      step();
      chk_out("skip0", 64'hDDDD_0000_0000_0003, 2'd3, 1'b1);
      chk("skip.ready_in2", {60'd0, ReadyIn}, 64'b0001);
      step();
      chk_out("skip1", 64'hAAAA_0000_0000_0000, 2'd0, 1'b1);

      // Single request on C with a full output and ReadyOut=1.
      InC = 64'hDEAD_BEEF_0000_0002;
      ValidIn = 4'b0100;
      #1;
      chk("single.ready_in", {60'd0, ReadyIn}, 64'b0100);
      step();
      ValidIn = 4'b0000;
      chk_out("single", 64'hDEAD_BEEF_0000_0002, 2'd2, 1'b1);

      // Drain only.
      step();
      chk_out("drain", 64'hDEAD_BEEF_0000_0002, 2'd2, 1'b0);

      // Pointer should be 3 after granting C and draining.
      InA = 64'h0000_0000_0000_00A0; InD = 64'd5;
      ValidIn = 4'b1001;
      #1;
      chk("ptr3.ready_in", {60'd0, ReadyIn}, 64'b1000);
      step();
      chk_out("load5", 64'd5, 2'd3, 1'b1);

      // Backpressure for three cycles.
      InB = 64'hBBBB_0000_0000_0001; InD = 64'hDDDD_0000_0000_0009;
      ValidIn = 4'b1010; ReadyOut = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp%0d.ready_in", i), {60'd0, ReadyIn}, 64'd0);
         step();
         chk_out($sformatf("bp%0d", i), 64'd5, 2'd3, 1'b1);
      end
      ReadyOut = 1'b1;
      #1;
      chk("bp_rel.ready_in", {60'd0, ReadyIn}, 64'b0010);
      step();
      chk_out("bp_rel", 64'hBBBB_0000_0000_0001, 2'd1, 1'b1);

      // Asynchronous reset with a held word.
      ReadyOut = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async_rst", 64'd0, 2'd0, 1'b0);
      chk("async_rst.ready_in", {60'd0, ReadyIn}, 64'd0);
      ValidIn = 4'b0000;
      step();
      rst_n = 1'b1;
      step(); step();
      chk_out("rst_rel", 64'd0, 2'd0, 1'b0);
      chk("rst_rel.ready_in", {60'd0, ReadyIn}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rr_arb_quadmux_64bit.md
Name: rr_arb_quadmux_64bit

Overview:
- Four-channel, 64-bit round-robin arbitration stage.
- Generates the 2-bit select for an internal quadmux_64bit instance and registers the selected word for a single downstream consumer.
- Sits directly around the 4:1 datapath mux: it feeds S and captures Out, giving a valid/ready handshake on all five channels.
- Throughput: one word per cycle. Latency: one cycle.

Parameters:
- WIDTH, 64, data width. Fixed at 64 by the quadmux_64bit datapath; any other value is unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- InA  input  64  channel 0 data.
- InB  input  64  channel 1 data.
- InC  input  64  channel 2 data.
- InD  input  64  channel 3 data.
- ValidIn  input  4  per-channel request; bit i belongs to channel i (A=0 … D=3).
- ReadyIn  output  4  per-channel accept; combinational; at most one bit high.
- Out  output  64  registered winning word.
- ValidOut  output  1  Out holds an unconsumed word.
- ReadyOut  input  1  downstream accepts Out this cycle.
- Grant  output  2  channel index of the word currently in Out (registered).

Behaviour:
- Reset (rst_n low, asynchronous): Out=0, ValidOut=0, Grant=0, priority pointer Ptr=0. ReadyIn is forced to 0 while rst_n is low. Reset mid-transfer discards the held word; no handshake completes in that cycle.
- Load enable: LoadEn = (~ValidOut | ReadyOut) & (|ValidIn).
- Arbitration (combinational):
  - Search order is Ptr, Ptr+1, Ptr+2, Ptr+3, all mod 4.
  - Sel = first index i in that order with ValidIn[i]=1.
  - Sel drives S of the quadmux_64bit instance.
- ReadyIn[i] = LoadEn & (Sel==i). All other bits are 0.
  - ReadyIn may depend combinationally on ValidIn and ReadyOut.
  - ReadyIn never depends on the InA..InD data.
- On each clock edge with LoadEn=1:
  - Out <= mux output.
  - Grant <= Sel.
  - ValidOut <= 1.
  - Ptr <= Sel+1 mod 4 (3 wraps to 0).
- On each edge with LoadEn=0:
  - If ValidOut & ReadyOut: ValidOut <= 0; Out and Grant hold their values.
  - Otherwise: all state holds.
  - Ptr is unchanged whenever no grant occurs.
- Backpressure: when ValidOut=1 and ReadyOut=0, Out, Grant and ValidOut are stable and ReadyIn=0000.
- Simultaneous drain and fill: when ValidOut=1, ReadyOut=1 and a request is present, the old word is consumed and the new word is loaded on the same edge. ValidOut stays 1, with no bubble.
- Fairness: a channel that holds ValidIn high is granted within at most 4 consecutive grants.
- Input protocol: a requester holds ValidIn and its data stable until ReadyIn is seen. The block does not check this.
- Out changes only on load edges or reset.

Test Plan:
- Reset: assert rst_n=0 mid-stream with ValidOut=1 -> Out=0, ValidOut=0, Grant=0, ReadyIn=0000 immediately, without waiting for clk. After release with ValidIn=0000 -> all outputs remain 0.
- Single request: ValidIn=0100, InC=64'hDEAD_BEEF_0000_0002, ReadyOut=1 -> ReadyIn=0100 that cycle. Next cycle Out=64'hDEAD_BEEF_0000_0002, Grant=2, ValidOut=1; Ptr becomes 3.
- Round robin with wrap: ValidIn=1111 held, ReadyOut=1, data A=1, B=2, C=3, D=4 -> Out sequence 1,2,3,4,1 on consecutive cycles, Grant sequence 0,1,2,3,0.
- Backpressure: ValidOut=1 with Out=64'h5, ReadyOut=0 for 3 cycles, ValidIn=1010 -> ReadyIn=0000 and Out/Grant stable for all 3 cycles. ReadyOut=1 -> channel 1 or 3 is loaded per Ptr in the same cycle.
- Priority skip: Ptr=1, ValidIn=1001 -> channel 3 granted first (Grant=3), then Ptr=0 and channel 0 is granted next.
- Drain only: ValidOut=1, ReadyOut=1, ValidIn=0000 -> ValidOut=0 next cycle, Out unchanged, Ptr unchanged.
